// File: rtl/dtack_generator.sv
// dtack_generator
// Generates DTACK_L / BERR_L for a 68000 bus cycle. On-chip ROM, RAM and IO
// are acknowledged after a fixed number of wait cycles. DRAM, CAN and
// off-board regions are acknowledged by their own responder, with a bus error
// if that responder stays silent for too long. Unmapped or overlapping decodes
// get a bus error. ErrorCount counts bus errors and saturates at 255.
//
// Ports
//   Clk, Reset_H                      clock, synchronous active-high reset
//   AS_L, UDS_L, LDS_L                CPU address and data strobes (active low)
//   OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H
//                                     internally acknowledged region selects
//   DramSelect_H, CanBusSelect_H, OffBoardMemory_H
//                                     externally acknowledged region selects
//   DramDtack_L, CanBusDtack_L, OffBoardDtack_L
//                                     responder acknowledges (active low)
//   DTACK_L, BERR_L                   registered acknowledge / bus error to CPU
//   ErrorCount                        saturating count of bus errors
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no access in progress; waits for AS_L plus a data strobe
// WAIT_INT | internal region: counting wait cycles (or decode error pending)
// WAIT_EXT | external region: waiting for its responder or for the timeout
// ACK      | DTACK_L held low until AS_L is released
// BERR     | BERR_L held low until AS_L is released
module dtack_generator #(
    parameter int unsigned ROM_WAIT       = 0,
    parameter int unsigned RAM_WAIT       = 1,
    parameter int unsigned IO_WAIT        = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic       Clk,
    input  logic       Reset_H,
    input  logic       AS_L,
    input  logic       UDS_L,
    input  logic       LDS_L,
    input  logic       OnChipRomSelect_H,
    input  logic       OnChipRamSelect_H,
    input  logic       IOSelect_H,
    input  logic       DramSelect_H,
    input  logic       CanBusSelect_H,
    input  logic       OffBoardMemory_H,
    input  logic       DramDtack_L,
    input  logic       CanBusDtack_L,
    input  logic       OffBoardDtack_L,
    output logic       DTACK_L,
    output logic       BERR_L,
    output logic [7:0] ErrorCount
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_INT,
        ST_WAIT_EXT,
        ST_ACK,
        ST_BERR
    } state_t;

    localparam logic [9:0] ROM_W   = 10'(ROM_WAIT);
    localparam logic [9:0] RAM_W   = 10'(RAM_WAIT);
    localparam logic [9:0] IO_W    = 10'(IO_WAIT);
    // Counter value seen on the edge at which the timeout fires.
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [9:0] cnt_q, cnt_d;
    logic [9:0] wait_q, wait_d;
    logic [2:0] ext_sel_q, ext_sel_d;   // {offboard, can, dram} latched at start
    logic       dec_err_q, dec_err_d;
    logic       ext_ack_q, ext_ack_d;
    logic       armed_q, armed_d;
    logic       dtack_l_q, dtack_l_d;
    logic       berr_l_q, berr_l_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic [1:0] int_cnt;
    logic [1:0] ext_cnt;
    logic       one_int;
    logic       one_ext;
    logic       start;
    logic       ext_dtack_low;

    assign int_cnt = {1'b0, OnChipRomSelect_H} + {1'b0, OnChipRamSelect_H}
                   + {1'b0, IOSelect_H};
    assign ext_cnt = {1'b0, DramSelect_H} + {1'b0, CanBusSelect_H}
                   + {1'b0, OffBoardMemory_H};
    assign one_int = (int_cnt == 2'd1) && (ext_cnt == 2'd0);
    assign one_ext = (ext_cnt == 2'd1) && (int_cnt == 2'd0);

    // armed_q guarantees AS_L has been seen high since the last access or
    // reset, so a strobe held low across reset cannot start a new cycle.
    assign start = armed_q && !AS_L && (!UDS_L || !LDS_L);

    // Only the responder latched at the start of the cycle is listened to.
    assign ext_dtack_low = |(ext_sel_q & ~{OffBoardDtack_L, CanBusDtack_L, DramDtack_L});

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        ext_sel_d = ext_sel_q;
        dec_err_d = dec_err_q;
        ext_ack_d = 1'b0;
        armed_d   = armed_q | AS_L;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    armed_d   = 1'b0;
                    cnt_d     = 10'd0;
                    dec_err_d = 1'b0;
                    wait_d    = 10'd0;
                    ext_sel_d = {OffBoardMemory_H, CanBusSelect_H, DramSelect_H};
                    if (one_int) begin
                        state_d = ST_WAIT_INT;
                        if (OnChipRomSelect_H)      wait_d = ROM_W;
                        else if (OnChipRamSelect_H) wait_d = RAM_W;
                        else                        wait_d = IO_W;
                    end else if (one_ext) begin
                        state_d = ST_WAIT_EXT;
                    end else begin
                        // Bad decode rides through WAIT_INT so BERR_L lands
                        // one edge after the start, like a zero-wait access.
                        state_d   = ST_WAIT_INT;
                        dec_err_d = 1'b1;
                    end
                end
            end
            ST_WAIT_INT: begin
                if (AS_L)                 state_d = ST_IDLE;
                else if (dec_err_q)       state_d = ST_BERR;
                else if (cnt_q == wait_q) state_d = ST_ACK;
                else                      cnt_d   = cnt_q + 10'd1;
            end
            ST_WAIT_EXT: begin
                // A responder seen low is registered first, so DTACK_L follows
                // one edge later; an acknowledge on the timeout edge beats it.
                if (AS_L)                    state_d   = ST_IDLE;
                else if (ext_ack_q)          state_d   = ST_ACK;
                else if (ext_dtack_low)      ext_ack_d = 1'b1;
                else if (cnt_q == TO_LAST)   state_d   = ST_BERR;
                else                         cnt_d     = cnt_q + 10'd1;
            end
            ST_ACK, ST_BERR: begin
                if (AS_L) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d == ST_BERR) && (state_q != ST_BERR) && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;

        dtack_l_d = (state_d != ST_ACK);
        berr_l_d  = (state_d != ST_BERR);
    end

    always_ff @(posedge Clk) begin
        if (Reset_H) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 10'd0;
            wait_q    <= 10'd0;
            ext_sel_q <= 3'd0;
            dec_err_q <= 1'b0;
            ext_ack_q <= 1'b0;
            armed_q   <= 1'b0;
            dtack_l_q <= 1'b1;
            berr_l_q  <= 1'b1;
            err_cnt_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            ext_sel_q <= ext_sel_d;
            dec_err_q <= dec_err_d;
            ext_ack_q <= ext_ack_d;
            armed_q   <= armed_d;
            dtack_l_q <= dtack_l_d;
            berr_l_q  <= berr_l_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign DTACK_L    = dtack_l_q;
    assign BERR_L     = berr_l_q;
    assign ErrorCount = err_cnt_q;

endmodule

// File: tb/tb_dtack_generator.sv
// Testbench for dtack_generator. Random and directed bus cycles; each cycle's
// expected DTACK_L/BERR_L transitions (edge number, levels, ErrorCount) are
// computed from the access rules and queued; a monitor compares every output
// transition against the head of the queue.
module tb_dtack_generator;

    localparam int ROM_W = 0;
    localparam int RAM_W = 1;
    localparam int IO_W  = 3;
    localparam int TMO   = 16;

    logic       Clk = 1'b0;
    logic       Reset_H;
    logic       AS_L, UDS_L, LDS_L;
    logic       OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H;
    logic       DramSelect_H, CanBusSelect_H, OffBoardMemory_H;
    logic       DramDtack_L, CanBusDtack_L, OffBoardDtack_L;
    logic       DTACK_L, BERR_L;
    logic [7:0] ErrorCount;

    dtack_generator #(
        .ROM_WAIT(ROM_W), .RAM_WAIT(RAM_W), .IO_WAIT(IO_W), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clk(Clk), .Reset_H(Reset_H),
        .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
        .OnChipRomSelect_H(OnChipRomSelect_H), .OnChipRamSelect_H(OnChipRamSelect_H),
        .IOSelect_H(IOSelect_H), .DramSelect_H(DramSelect_H),
        .CanBusSelect_H(CanBusSelect_H), .OffBoardMemory_H(OffBoardMemory_H),
        .DramDtack_L(DramDtack_L), .CanBusDtack_L(CanBusDtack_L),
        .OffBoardDtack_L(OffBoardDtack_L),
        .DTACK_L(DTACK_L), .BERR_L(BERR_L), .ErrorCount(ErrorCount)
    );

    always #5 Clk = ~Clk;

    int edge_n = 0;
    always @(posedge Clk) edge_n <= edge_n + 1;

    typedef struct {
        logic dtack;
        logic berr;
        int   edge_i;
        int   err;
    } ev_t;

    ev_t  exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_err = 0;
    bit   mon_en = 1'b0;
    logic [1:0] prev_out = 2'b11;

    // sel bit order: 0 rom, 1 ram, 2 io, 3 dram, 4 can, 5 offboard
    localparam logic [5:0] S_ROM = 6'b000001, S_RAM = 6'b000010, S_IO  = 6'b000100;
    localparam logic [5:0] S_DRAM = 6'b001000, S_CAN = 6'b010000, S_OFF = 6'b100000;

    // Monitor: every change of {DTACK_L,BERR_L} must match the queued event.
    always @(negedge Clk) begin
        if (mon_en) begin
            ev_t e;
            n_cmp++;
            if (DTACK_L === 1'b0 && BERR_L === 1'b0) begin
                n_bad++;
                $display("FAIL exclusive: edge %0d DTACK_L=0 and BERR_L=0 together", edge_n);
            end
            if ({DTACK_L, BERR_L} !== prev_out) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: edge %0d got DTACK_L=%b BERR_L=%b err=%0d, none expected",
                             edge_n, DTACK_L, BERR_L, ErrorCount);
                end else begin
                    e = exp_q.pop_front();
                    if (DTACK_L !== e.dtack || BERR_L !== e.berr || edge_n != e.edge_i
                        || int'(ErrorCount) != e.err) begin
                        n_bad++;
                        $display("FAIL event: got DTACK_L=%b BERR_L=%b edge=%0d err=%0d, expected DTACK_L=%b BERR_L=%b edge=%0d err=%0d",
                                 DTACK_L, BERR_L, edge_n, ErrorCount, e.dtack, e.berr, e.edge_i, e.err);
                    end
                end
                prev_out = {DTACK_L, BERR_L};
            end
        end
    end

    // Offset from the start edge to the DTACK_L/BERR_L assertion. d is the
    // offset at which the selected external responder first drives low.
    function automatic void predict(input logic [5:0] sel, input int d,
                                    output int off, output bit is_berr);
        if ($countones(sel) != 1) begin off = 1;        is_berr = 1'b1; end
        else if (sel[0])          begin off = 1 + ROM_W; is_berr = 1'b0; end
        else if (sel[1])          begin off = 1 + RAM_W; is_berr = 1'b0; end
        else if (sel[2])          begin off = 1 + IO_W;  is_berr = 1'b0; end
        else if (d <= TMO)        begin off = d + 1;     is_berr = 1'b0; end
        else                      begin off = TMO;       is_berr = 1'b1; end
    endfunction

    task automatic set_sel(input logic [5:0] s);
        OnChipRomSelect_H = s[0]; OnChipRamSelect_H = s[1]; IOSelect_H = s[2];
        DramSelect_H = s[3]; CanBusSelect_H = s[4]; OffBoardMemory_H = s[5];
    endtask

    task automatic drive_ext(input logic [5:0] sel, input bit ack_low);
        logic [2:0] r;
        r = 3'($urandom);
        DramDtack_L = r[0]; CanBusDtack_L = r[1]; OffBoardDtack_L = r[2];
        if ($countones(sel) == 1) begin
            if (sel[3]) DramDtack_L     = !ack_low;
            if (sel[4]) CanBusDtack_L   = !ack_low;
            if (sel[5]) OffBoardDtack_L = !ack_low;
        end
    endtask

    task automatic release_bus();
        AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
        set_sel(6'd0);
        DramDtack_L = 1'b1; CanBusDtack_L = 1'b1; OffBoardDtack_L = 1'b1;
    endtask

    task automatic start_strobe(input logic [5:0] sel);
        AS_L = 1'b0;
        case ($urandom_range(2, 0))
            0:       {UDS_L, LDS_L} = 2'b00;
            1:       {UDS_L, LDS_L} = 2'b01;
            default: {UDS_L, LDS_L} = 2'b10;
        endcase
        set_sel(sel);
    endtask

    task automatic push_ev(input logic dt, input logic be, input int ei, input int er);
        ev_t e;
        e.dtack = dt; e.berr = be; e.edge_i = ei; e.err = er;
        exp_q.push_back(e);
    endtask

    task automatic access(input logic [5:0] sel, input int d, input bit abort_it);
        int e0, off, ex, p;
        bit is_berr;
        @(negedge Clk);
        start_strobe(sel);
        drive_ext(sel, 1'b0);
        e0 = edge_n + 1;
        predict(sel, d, off, is_berr);
        if (abort_it) ex = e0 + $urandom_range(off, 1);
        else          ex = e0 + off + $urandom_range(3, 1);
        if (!abort_it) begin
            if (is_berr && model_err < 255) model_err++;
            push_ev(is_berr, !is_berr, e0 + off, model_err);
            push_ev(1'b1, 1'b1, ex, model_err);
        end
        do begin
            @(negedge Clk);
            p = edge_n + 1;
            set_sel(6'($urandom));              // latched decode must not follow
            drive_ext(sel, p >= e0 + d);
            if (p >= ex) release_bus();
        end while (p < ex);
        repeat ($urandom_range(2, 0)) @(negedge Clk);
    endtask

    // Reset pulse roff edges after the start, strobes held low through it.
    task automatic reset_during(input logic [5:0] sel, input int roff);
        int e0, off, r, p;
        bit is_berr;
        @(negedge Clk);
        start_strobe(sel);
        drive_ext(sel, 1'b0);
        e0 = edge_n + 1;
        predict(sel, 0, off, is_berr);
        r = e0 + roff;
        if (roff > off) begin
            if (is_berr && model_err < 255) model_err++;
            push_ev(is_berr, !is_berr, e0 + off, model_err);
            push_ev(1'b1, 1'b1, r, 0);
        end
        do begin
            @(negedge Clk);
            p = edge_n + 1;
            if (p == r) Reset_H = 1'b1;
        end while (p < r);
        @(negedge Clk);
        Reset_H = 1'b0;
        model_err = 0;
        repeat (6) @(negedge Clk);              // AS_L still low: nothing may start
        release_bus();
        @(negedge Clk);
    endtask

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic random_accesses(input int n);
        logic [5:0] s;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(9, 0))
                0: s = S_ROM;  1: s = S_RAM;  2: s = S_IO;
                3, 8: s = S_DRAM;  4, 9: s = S_CAN;  5: s = S_OFF;
                6: s = 6'd0;
                default: s = 6'($urandom);
            endcase
            access(s, $urandom_range(TMO + 3, 1), $urandom_range(7, 0) == 0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset_H = 1'b1;
        release_bus();
        repeat (3) @(negedge Clk);
        Reset_H = 1'b0;
        check8("reset_dtack", {7'd0, DTACK_L}, 8'd1);
        check8("reset_berr", {7'd0, BERR_L}, 8'd1);
        check8("reset_errcount", ErrorCount, 8'd0);
        mon_en = 1'b1;
        @(negedge Clk);

        access(S_ROM, 0, 1'b0);
        access(S_IO, 0, 1'b0);
        access(S_RAM, 0, 1'b0);
        access(S_DRAM, 5, 1'b0);
        access(S_CAN, 99, 1'b0);
        access(6'd0, 0, 1'b0);
        access(S_IO | S_DRAM, 0, 1'b0);
        access(S_DRAM, TMO, 1'b0);
        access(S_OFF, TMO - 1, 1'b0);
        access(S_CAN, TMO + 1, 1'b0);
        access(S_IO, 0, 1'b1);
        reset_during(S_IO, 2);
        access(S_IO, 0, 1'b0);

        random_accesses(150);

        repeat (300) access(S_CAN, 99, 1'b0);
        check8("errcount_saturated", ErrorCount, 8'd255);

        random_accesses(100);
        reset_during(S_ROM, 3);
        reset_during(6'd0, 4);
        random_accesses(30);

        repeat (4) @(negedge Clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events: %0d expected transitions never seen, expected 0", exp_q.size());
        end
        check8("final_errcount", ErrorCount, 8'(model_err));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dtack_generator.md
DTACK_GENERATOR -- requirements
Module: dtack_generator

Interface
REQ-001 Parameter ROM_WAIT, default 0: wait cycles inserted for on-chip ROM accesses.
REQ-002 Parameter RAM_WAIT, default 1: wait cycles inserted for on-chip RAM accesses.
REQ-003 Parameter IO_WAIT, default 3: wait cycles inserted for IO accesses.
REQ-004 Parameter TIMEOUT_CYCLES, default 1023 (10-bit): cycles allowed for an externally acknowledged access before bus error.
REQ-005 Clk  input  1  single system clock; all state updates on the rising edge.
REQ-006 Reset_H  input  1  synchronous, active-high reset.
REQ-007 AS_L  input  1  68000 address strobe, active low.
REQ-008 UDS_L, LDS_L  input  1 each  data strobes, active low.
REQ-009 OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H  input  1 each  internally acknowledged region selects.
REQ-010 DramSelect_H, CanBusSelect_H, OffBoardMemory_H  input  1 each  externally acknowledged region selects.
REQ-011 DramDtack_L, CanBusDtack_L, OffBoardDtack_L  input  1 each  acknowledge from the matching external responder, active low.
REQ-012 DTACK_L  output  1  registered data-transfer acknowledge to CPU, active low.
REQ-013 BERR_L  output  1  registered bus error to CPU, active low.
REQ-014 ErrorCount  output  8  count of bus-error cycles since reset, saturating.

Function
REQ-015 States: IDLE, WAIT_INT, WAIT_EXT, ACK, BERR; all outputs are registered.
REQ-016 Access start: in IDLE, AS_L=0 and (UDS_L=0 or LDS_L=0) at edge E0 -> selects sampled and latched at E0; later select changes are ignored until the cycle ends.
REQ-017 Exactly one internal select at E0 -> WAIT_INT, 10-bit counter cleared to 0, wait value W from the matching parameter.
REQ-018 WAIT_INT: counter increments each edge; DTACK_L driven low at edge E0+1+W (ROM_WAIT=0 gives DTACK_L low at E0+1); state -> ACK.
REQ-019 Exactly one external select at E0 -> WAIT_EXT, counter cleared to 0.
REQ-020 WAIT_EXT: the selected responder's Dtack_L sampled low at edge Ek -> DTACK_L low at Ek+1, state -> ACK; other responders' Dtack_L ignored.
REQ-021 WAIT_EXT timeout: no acknowledge sampled by edge E0+TIMEOUT_CYCLES -> BERR_L low at that edge, state -> BERR; DTACK_L stays high.
REQ-022 Zero selects (unmapped) or more than one select (decode overlap) at E0 -> BERR_L low at E0+1, state -> BERR.
REQ-023 ACK and BERR: output held low while AS_L=0; AS_L sampled high at edge Ex -> DTACK_L/BERR_L high at Ex, state -> IDLE.
REQ-024 DTACK_L and BERR_L are never low simultaneously.
REQ-025 Abort: AS_L sampled high in WAIT_INT or WAIT_EXT -> IDLE at that edge; DTACK_L and BERR_L remain high; ErrorCount unchanged.
REQ-026 Acknowledge and timeout on the same edge in WAIT_EXT: acknowledge wins, DTACK_L low, no BERR.
REQ-027 ErrorCount increments by 1 on each entry to BERR; holds at 255.
REQ-028 IDLE requires AS_L high for at least one edge after ACK/BERR before a new access starts; back-to-back cycles re-arm correctly.
REQ-029 Counter is 10 bits; it does not wrap within a cycle (timeout fires first).

Reset
REQ-030 Reset_H=1 at an edge -> state IDLE, counter 0, DTACK_L=1, BERR_L=1, ErrorCount=0, at that edge, regardless of state.
REQ-031 Reset_H mid-access (WAIT_*, ACK, BERR) -> outputs released at that edge; with AS_L still low after reset release, no new access starts until AS_L has been sampled high.
REQ-032 Reset has priority over every other event on the same edge.

Verification
REQ-033 ROM read: AS_L, UDS_L low with OnChipRomSelect_H=1 at E0 -> DTACK_L low at E0+1, high on the first edge AS_L is sampled high.
REQ-034 IO access with IO_WAIT=3 -> DTACK_L low at E0+4, exactly 3 wait cycles; RAM_WAIT=1 -> DTACK_L low at E0+2.
REQ-035 DRAM access with DramDtack_L low at E0+5 -> DTACK_L low at E0+6; CanBusDtack_L toggling during the access has no effect.
REQ-036 CAN access, CanBusDtack_L never asserted, TIMEOUT_CYCLES=16 -> BERR_L low at E0+16, ErrorCount 0->1; 300 such cycles -> ErrorCount=255.
REQ-037 Unmapped address (all selects 0) -> BERR_L low at E0+1. IOSelect_H and DramSelect_H both high -> BERR_L low at E0+1.
REQ-038 Reset_H pulsed during IO WAIT_INT with AS_L held low -> DTACK_L stays high until AS_L goes high; the next strobe then completes normally.
